bundle_acc: RTL and testbench



---
 rtl/bundle_acc_if.sv | 27 ++
 rtl/bundle_acc.sv | 134 +++++++++++++
 tb/tb_bundle_acc.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bundle_acc_if.sv
// Result-path bundle between core, bundler and host.
// Carries the accumulate inputs, the write-back pulse and the host valid/ready pair.
interface bundle_acc_if #(
    parameter int DIM = 1023
);
    logic           store;
    logic [DIM:0]   core_result;
    logic           last;
    logic [DIM:0]   tie_vec;
    logic           wb_en;
    logic [DIM:0]   wb_data;
    logic           res_valid;
    logic [DIM:0]   res_data;
    logic           res_ready;

    // Driver side: core plus host.
    modport master (
        output store, core_result, last, tie_vec, res_ready,
        input  wb_en, wb_data, res_valid, res_data
    );

    // Bundler side.
    modport slave (
        input  store, core_result, last, tie_vec, res_ready,
        output wb_en, wb_data, res_valid, res_data
    );
endinterface

// File: rtl/bundle_acc.sv
// Per-bit majority-vote bundler for hypervectors.
// Each bit has a saturating signed counter. Stored vectors vote +1 or -1 per bit.
// On last, the sign of every counter becomes the result. A zero counter takes the
// corresponding tie_vec bit. The result is pulsed out once on wb_en and held for
// the host until it is accepted.
//
//   state | meaning
//   IDLE  | bundle empty, waiting for the first store or last
//   ACC   | accumulating stored vectors
//   SIGN  | one cycle: counters are final, sign vector is formed at exit
//   HOLD  | result valid, waiting for host res_ready
module bundle_acc #(
    parameter int DIM   = 1023,
    parameter int CNT_W = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          run,
    bundle_acc_if.slave   bus,
    output logic [15:0]   vec_cnt,
    output logic          sat,
    output logic          err
);

    typedef enum logic [1:0] {IDLE, ACC, SIGN, HOLD} state_t;
    typedef logic [CNT_W-1:0] cnt_t;

    // Symmetric range: the most negative code is never used, so votes stay balanced.
    localparam cnt_t CNT_MAX = {1'b0, {(CNT_W-1){1'b1}}};
    localparam cnt_t CNT_MIN = {1'b1, {(CNT_W-2){1'b0}}, 1'b1};

    state_t                    state_q, state_d;
    logic [DIM:0][CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]               vec_cnt_q, vec_cnt_d;
    logic                      sat_q, sat_d;
    logic                      err_q, err_d;
    logic [DIM:0]              res_q, res_d;
    logic                      res_valid_q, res_valid_d;
    logic                      wb_en_q, wb_en_d;

    // Next-state logic: accumulate, form sign vector, hold for host handshake.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        vec_cnt_d   = vec_cnt_q;
        sat_d       = sat_q;
        err_d       = err_q;
        res_d       = res_q;
        res_valid_d = res_valid_q;
        wb_en_d     = 1'b0;

        case (state_q)
            IDLE, ACC: begin
                if (bus.store) begin
                    for (int i = 0; i <= DIM; i++) begin
                        if (bus.core_result[i]) begin
                            if (cnt_q[i] == CNT_MAX) sat_d = 1'b1;
                            else                     cnt_d[i] = cnt_q[i] + cnt_t'(1);
                        end else begin
                            if (cnt_q[i] == CNT_MIN) sat_d = 1'b1;
                            else                     cnt_d[i] = cnt_q[i] - cnt_t'(1);
                        end
                    end
                    if (vec_cnt_q != 16'hFFFF) vec_cnt_d = vec_cnt_q + 16'd1;
                    state_d = ACC;
                end
                // A coincident store has already been folded in above.
                if (bus.last) state_d = SIGN;
            end
            SIGN: begin
                for (int i = 0; i <= DIM; i++) begin
                    if (cnt_q[i] == '0) res_d[i] = bus.tie_vec[i];
                    else                res_d[i] = ~cnt_q[i][CNT_W-1];
                end
                res_valid_d = 1'b1;
                wb_en_d     = 1'b1;
                state_d     = HOLD;
                if (bus.store || bus.last) err_d = 1'b1;
            end
            HOLD: begin
                if (bus.store || bus.last) err_d = 1'b1;
                if (bus.res_ready) begin
                    res_valid_d = 1'b0;
                    cnt_d       = '0;
                    vec_cnt_d   = '0;
                    sat_d       = 1'b0;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; run low clears everything synchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_cnt_q   <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
        end else if (!run) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            vec_cnt_q   <= '0;
            sat_q       <= 1'b0;
            err_q       <= 1'b0;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            wb_en_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            vec_cnt_q   <= vec_cnt_d;
            sat_q       <= sat_d;
            err_q       <= err_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            wb_en_q     <= wb_en_d;
        end
    end

    assign bus.wb_en     = wb_en_q;
    assign bus.wb_data   = res_q;
    assign bus.res_data  = res_q;
    assign bus.res_valid = res_valid_q;
    assign vec_cnt       = vec_cnt_q;
    assign sat           = sat_q;
    assign err           = err_q;

endmodule

// File: tb/tb_bundle_acc.sv
// Bench for bundle_acc with DIM=7, CNT_W=4. The reference model keeps one integer
// vote total per bit, clamped to +/-7, and takes the sign of each total.
module tb_bundle_acc;

    logic        clk;
    logic        rst_n;
    logic        run;
    logic [15:0] vec_cnt;
    logic        sat;
    logic        err;

    int tests = 0;
    int fails = 0;

    bundle_acc_if #(.DIM(7)) bus();

    bundle_acc #(.DIM(7), .CNT_W(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .run     (run),
        .bus     (bus),
        .vec_cnt (vec_cnt),
        .sat     (sat),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model
    int m_cnt [8];
    int m_n;
    bit m_sat;

    function automatic void m_clear();
        for (int i = 0; i < 8; i++) m_cnt[i] = 0;
        m_n   = 0;
        m_sat = 1'b0;
    endfunction

    function automatic void m_store(logic [7:0] v);
        for (int i = 0; i < 8; i++) begin
            int t;
            t = m_cnt[i] + (v[i] ? 1 : -1);
            if (t > 7)  begin t = 7;  m_sat = 1'b1; end
            if (t < -7) begin t = -7; m_sat = 1'b1; end
            m_cnt[i] = t;
        end
        if (m_n < 65535) m_n++;
    endfunction

    function automatic logic [7:0] m_result(logic [7:0] tie);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            if (m_cnt[i] > 0)      r[i] = 1'b1;
            else if (m_cnt[i] < 0) r[i] = 1'b0;
            else                   r[i] = tie[i];
        end
        return r;
    endfunction

    // Stimulus helpers (no checking)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit st, input logic [7:0] d, input bit ls);
        bus.store       = st;
        bus.core_result = d;
        bus.last        = ls;
        tick();
        bus.store = 1'b0;
        bus.last  = 1'b0;
    endtask

    task automatic accept();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
        m_clear();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tests++; if (bus.res_valid !== 1'b0) begin fails++; $display("FAIL reset_res_valid: got %b exp 0", bus.res_valid); end
        tick();
        tests++; if (bus.wb_en !== 1'b0) begin fails++; $display("FAIL reset_wb_en: got %b exp 0", bus.wb_en); end
        tests++; if (bus.res_data !== 8'h00) begin fails++; $display("FAIL reset_res_data: got %h exp 00", bus.res_data); end
        tests++; if (bus.wb_data !== 8'h00) begin fails++; $display("FAIL reset_wb_data: got %h exp 00", bus.wb_data); end
        tests++; if (vec_cnt !== 16'd0) begin fails++; $display("FAIL reset_vec_cnt: got %0d exp 0", vec_cnt); end
        tests++; if ({sat, err} !== 2'b00) begin fails++; $display("FAIL reset_sat_err: got %b exp 00", {sat, err}); end
        rst_n = 1'b1;
        tick();
        m_clear();
    endtask

    task automatic test_basic();
        logic [7:0] exp;
        bus.tie_vec = 8'h00;
        drive(1'b1, 8'hF0, 1'b0); m_store(8'hF0);
        drive(1'b1, 8'hCC, 1'b0); m_store(8'hCC);
        drive(1'b1, 8'hAA, 1'b0); m_store(8'hAA);
        exp = m_result(8'h00);
        drive(1'b0, 8'h00, 1'b1);
        tests++; if ({bus.wb_en, bus.res_valid} !== 2'b00) begin fails++; $display("FAIL basic_sign_cycle: got wb_en,valid=%b exp 00", {bus.wb_en, bus.res_valid}); end
        tick();
        tests++; if ({bus.wb_en, bus.res_valid} !== 2'b11) begin fails++; $display("FAIL basic_wb_pulse: got wb_en,valid=%b exp 11", {bus.wb_en, bus.res_valid}); end
        tests++; if (bus.res_data !== exp || exp !== 8'hE8) begin fails++; $display("FAIL basic_res_data: got %h exp %h (E8)", bus.res_data, exp); end
        tests++; if (bus.wb_data !== exp) begin fails++; $display("FAIL basic_wb_data: got %h exp %h", bus.wb_data, exp); end
        tests++; if (vec_cnt !== 16'(m_n)) begin fails++; $display("FAIL basic_vec_cnt: got %0d exp %0d", vec_cnt, m_n); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL basic_err: got %b exp 0", err); end
        tick();
        tests++; if ({bus.wb_en, bus.res_valid} !== 2'b01) begin fails++; $display("FAIL basic_pulse_end: got wb_en,valid=%b exp 01", {bus.wb_en, bus.res_valid}); end
        accept();
        tests++; if (bus.res_valid !== 1'b0 || vec_cnt !== 16'd0) begin fails++; $display("FAIL basic_accept: got valid=%b vec_cnt=%0d exp 0 0", bus.res_valid, vec_cnt); end
        tests++; if (bus.res_data !== exp) begin fails++; $display("FAIL basic_data_kept: got %h exp %h", bus.res_data, exp); end
    endtask

    task automatic test_tie_lastore();
        logic [7:0] exp;
        bus.tie_vec = 8'h5A;
        drive(1'b1, 8'h0F, 1'b0); m_store(8'h0F);
        drive(1'b1, 8'hF0, 1'b1); m_store(8'hF0);
        exp = m_result(8'h5A);
        tests++; if (vec_cnt !== 16'd2) begin fails++; $display("FAIL tie_vec_cnt: got %0d exp 2", vec_cnt); end
        tick();
        tests++; if (bus.res_data !== exp || exp !== 8'h5A) begin fails++; $display("FAIL tie_res_data: got %h exp %h", bus.res_data, exp); end
        tests++; if (bus.wb_en !== 1'b1) begin fails++; $display("FAIL tie_wb_en: got %b exp 1", bus.wb_en); end
        accept();
    endtask

    task automatic test_saturation();
        logic [7:0] exp;
        bus.tie_vec = 8'h00;
        for (int k = 0; k < 17; k++) begin
            logic [7:0] v;
            v = (k < 10) ? 8'hFF : 8'h00;
            drive(1'b1, v, 1'b0); m_store(v);
            tests++; if (sat !== m_sat) begin fails++; $display("FAIL sat_step%0d: got %b exp %b", k, sat, m_sat); end
        end
        exp = m_result(8'h00);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        tests++; if (bus.res_data !== exp || exp !== 8'h00) begin fails++; $display("FAIL sat_res_data: got %h exp %h", bus.res_data, exp); end
        tests++; if (vec_cnt !== 16'd17 || sat !== 1'b1) begin fails++; $display("FAIL sat_final: got vec_cnt=%0d sat=%b exp 17 1", vec_cnt, sat); end
        accept();
        tests++; if (sat !== 1'b0) begin fails++; $display("FAIL sat_cleared: got %b exp 0", sat); end
    endtask

    task automatic test_last_no_store();
        bus.tie_vec = 8'hA5;
        drive(1'b0, 8'h00, 1'b1);
        tests++; if (vec_cnt !== 16'd0) begin fails++; $display("FAIL nostore_vec_cnt: got %0d exp 0", vec_cnt); end
        tick();
        tests++; if (bus.res_data !== 8'hA5 || bus.wb_en !== 1'b1) begin fails++; $display("FAIL nostore_result: got %h wb_en=%b exp a5 1", bus.res_data, bus.wb_en); end
        tick();
        tests++; if (bus.wb_en !== 1'b0) begin fails++; $display("FAIL nostore_single_pulse: got %b exp 0", bus.wb_en); end
        accept();
    endtask

    task automatic test_backpressure();
        logic [7:0] exp;
        bus.tie_vec = 8'h3C;
        for (int k = 0; k < 3; k++) begin
            logic [7:0] v;
            v = 8'($urandom);
            drive(1'b1, v, 1'b0); m_store(v);
        end
        exp = m_result(8'h3C);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            bus.res_ready = 1'b0;
            drive(1'b1, 8'($urandom), 1'b0);
            tests++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp) begin fails++; $display("FAIL bp_hold%0d: got valid=%b data=%h exp 1 %h", k, bus.res_valid, bus.res_data, exp); end
            tests++; if (vec_cnt !== 16'(m_n) || err !== 1'b1 || bus.wb_en !== 1'b0) begin fails++; $display("FAIL bp_state%0d: got vec_cnt=%0d err=%b wb_en=%b exp %0d 1 0", k, vec_cnt, err, bus.wb_en, m_n); end
        end
        accept();
        tests++; if (bus.res_valid !== 1'b0 || vec_cnt !== 16'd0 || sat !== 1'b0) begin fails++; $display("FAIL bp_accept: got valid=%b vec_cnt=%0d sat=%b exp 0 0 0", bus.res_valid, vec_cnt, sat); end
        tests++; if (err !== 1'b1 || bus.res_data !== exp) begin fails++; $display("FAIL bp_sticky: got err=%b data=%h exp 1 %h", err, bus.res_data, exp); end
        // counters must be empty: a single 0x01 vote decides every bit
        bus.tie_vec = 8'h00;
        drive(1'b1, 8'h01, 1'b1); m_store(8'h01);
        tick();
        tests++; if (bus.res_data !== m_result(8'h00)) begin fails++; $display("FAIL bp_counters_clear: got %h exp %h", bus.res_data, m_result(8'h00)); end
        accept();
        run = 1'b0;
        tick();
        run = 1'b1;
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL bp_err_clear: got %b exp 0", err); end
    endtask

    task automatic test_run_clear();
        bus.tie_vec = 8'h00;
        drive(1'b1, 8'h3F, 1'b0);
        drive(1'b1, 8'h31, 1'b1);
        tick();
        tick();
        run = 1'b0;
        drive(1'b1, 8'hFF, 1'b0);
        tests++; if (bus.res_valid !== 1'b0 || vec_cnt !== 16'd0) begin fails++; $display("FAIL run_clear: got valid=%b vec_cnt=%0d exp 0 0", bus.res_valid, vec_cnt); end
        tests++; if (bus.res_data !== 8'h00 || sat !== 1'b0) begin fails++; $display("FAIL run_clear_data: got %h sat=%b exp 00 0", bus.res_data, sat); end
        run = 1'b1;
        m_clear();
        drive(1'b1, 8'hFF, 1'b0); m_store(8'hFF);
        drive(1'b0, 8'h00, 1'b1);
        tick();
        tests++; if (bus.res_data !== m_result(8'h00) || vec_cnt !== 16'd1) begin fails++; $display("FAIL run_next_bundle: got %h vec_cnt=%0d exp %h 1", bus.res_data, vec_cnt, m_result(8'h00)); end
        accept();
    endtask

    task automatic test_async_reset();
        drive(1'b1, 8'h12, 1'b0);
        drive(1'b1, 8'h34, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        tests++; if (bus.res_data !== 8'h00 || vec_cnt !== 16'd0) begin fails++; $display("FAIL async_rst: got data=%h vec_cnt=%0d exp 00 0", bus.res_data, vec_cnt); end
        tests++; if ({bus.res_valid, bus.wb_en, sat, err} !== 4'b0000) begin fails++; $display("FAIL async_rst_flags: got %b exp 0000", {bus.res_valid, bus.wb_en, sat, err}); end
        tick();
        rst_n = 1'b1;
        tick();
        m_clear();
    endtask

    task automatic test_random();
        for (int b = 0; b < 25; b++) begin
            logic [7:0] tie;
            logic [7:0] exp;
            int n;
            bit lastore;
            tie = 8'($urandom);
            bus.tie_vec = tie;
            n = $urandom_range(0, 22);
            lastore = (n > 0) && ($urandom_range(0, 1) == 1);
            for (int k = 0; k < n; k++) begin
                logic [7:0] v;
                v = 8'($urandom);
                if ($urandom_range(0, 3) == 0) drive(1'b0, 8'h00, 1'b0);
                drive(1'b1, v, lastore && (k == n - 1));
                m_store(v);
            end
            if (!lastore) drive(1'b0, 8'h00, 1'b1);
            exp = m_result(tie);
            tick();
            tests++; if (bus.res_data !== exp || bus.wb_en !== 1'b1) begin fails++; $display("FAIL rand%0d_result: got %h wb_en=%b exp %h 1", b, bus.res_data, bus.wb_en, exp); end
            tests++; if (vec_cnt !== 16'(m_n) || sat !== m_sat || err !== 1'b0) begin fails++; $display("FAIL rand%0d_status: got vec_cnt=%0d sat=%b err=%b exp %0d %b 0", b, vec_cnt, sat, err, m_n, m_sat); end
            for (int d = $urandom_range(1, 3); d > 0; d--) tick();
            tests++; if (bus.res_valid !== 1'b1 || bus.wb_en !== 1'b0) begin fails++; $display("FAIL rand%0d_hold: got valid=%b wb_en=%b exp 1 0", b, bus.res_valid, bus.wb_en); end
            accept();
            tests++; if (bus.res_valid !== 1'b0 || vec_cnt !== 16'd0) begin fails++; $display("FAIL rand%0d_accept: got valid=%b vec_cnt=%0d exp 0 0", b, bus.res_valid, vec_cnt); end
        end
    endtask

    initial begin
        rst_n           = 1'b0;
        run             = 1'b1;
        bus.store       = 1'b0;
        bus.core_result = 8'h00;
        bus.last        = 1'b0;
        bus.tie_vec     = 8'h00;
        bus.res_ready   = 1'b0;
        m_clear();
        test_reset();
        test_basic();
        test_tie_lastore();
        test_saturation();
        test_last_no_store();
        test_backpressure();
        test_run_clear();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
